// File: rtl/verilogicoin_pkg.sv
// Shared types and constants for the key verification path.
// State encodings, key tag and field widths.
package verilogicoin_pkg;

    localparam int PUBKEY_W = 11;
    localparam int KEY_W    = 8;
    localparam int TABLE_W  = 258;

    localparam logic [2:0] KEY_TAG_VALID = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HASH,
        ST_RESP
    } state_e;

endpackage

// File: rtl/key_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches upward from rr_ptr with wrap; returns one-hot grant and index.
module key_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [2:0]         rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [2:0]         grant_idx,
    output logic               grant_vld
);

    logic [3:0] cand;

    // First valid requester at or after rr_ptr, wrapping at NUM_REQ
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + 4'(k);
            if (cand >= 4'(NUM_REQ)) begin
                cand = cand - 4'(NUM_REQ);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_vld && cand == 4'(i) && req_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = 3'(i);
                    grant[i]  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pearson_hash8.sv
// Iterative 8-bit table hash: one step per clock, counter saturates at 7.
// Each step folds three table bits selected by (hash ^ message).
module pearson_hash8
    import verilogicoin_pkg::*;
(
    input  logic               clock,
    input  logic               resetn,
    input  logic [TABLE_W-1:0] random_table,
    input  logic [KEY_W-1:0]   message,
    output logic [2:0]         counter,
    output logic [KEY_W-1:0]   hash
);

    logic [2:0]       counter_q, counter_d;
    logic [KEY_W-1:0] hash_q, hash_d;
    logic [KEY_W-1:0] idx;
    logic [2:0]       tbits;

    // One hash step per cycle until the counter saturates
    always_comb begin
        idx       = hash_q ^ message;
        tbits     = random_table[{1'b0, idx} +: 3];
        counter_d = counter_q;
        hash_d    = hash_q;
        if (counter_q != 3'b111) begin
            counter_d = counter_q + 3'd1;
            hash_d    = {hash_q[4:0], tbits} ^ message;
        end
    end

    // Engine state, cleared whenever resetn is low
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            counter_q <= '0;
            hash_q    <= '0;
        end else begin
            counter_q <= counter_d;
            hash_q    <= hash_d;
        end
    end

    assign counter = counter_q;
    assign hash    = hash_q;

endmodule

// File: rtl/key_verify_scheduler.sv
// Shares one pearson_hash8 among NUM_REQ key-verification requesters.
// Round-robin grant, load/hash/compare sequencing, tagged verdict.
module key_verify_scheduler
    import verilogicoin_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic [TABLE_W-1:0]          random_table,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*PUBKEY_W-1:0] req_public_key,
    input  logic [NUM_REQ*KEY_W-1:0]    req_input_key,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [2:0]                  rsp_id,
    output logic                        rsp_correct,
    output logic                        rsp_error,
    output logic                        busy
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [2:0] LAST_ID  = 3'(NUM_REQ - 1);

    state_e           state_q, state_d;
    logic [2:0]       rr_ptr_q, rr_ptr_d;
    logic [2:0]       id_q, id_d;
    logic [KEY_W-1:0] exp_q, exp_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             correct_q, correct_d;
    logic             error_q, error_d;
    logic [7:0]       tmo_q, tmo_d;
    logic             eng_resetn_q, eng_resetn_d;

    logic [NUM_REQ-1:0]  grant;
    logic [2:0]          grant_idx;
    logic                grant_vld;
    logic [PUBKEY_W-1:0] sel_pub;
    logic [KEY_W-1:0]    sel_key;
    logic [2:0]          eng_counter;
    logic [KEY_W-1:0]    eng_hash;

    key_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    pearson_hash8 u_engine (
        .clock        (clock),
        .resetn       (eng_resetn_q),
        .random_table (random_table),
        .message      (key_q),
        .counter      (eng_counter),
        .hash         (eng_hash)
    );

    // Select the winning requester's key fields
    always_comb begin
        sel_pub = '0;
        sel_key = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_pub = req_public_key[i*PUBKEY_W +: PUBKEY_W];
                sel_key = req_input_key[i*KEY_W +: KEY_W];
            end
        end
    end

    // Next state, latches and handshake outputs
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        id_d      = id_q;
        exp_d     = exp_q;
        key_d     = key_q;
        correct_d = correct_q;
        error_d   = error_q;
        tmo_d     = tmo_q;
        req_ready = '0;
        unique case (state_q)
            ST_IDLE: begin
                req_ready = grant;
                if (grant_vld) begin
                    exp_d     = sel_pub[KEY_W-1:0];
                    key_d     = sel_key;
                    id_d      = grant_idx;
                    correct_d = 1'b0;
                    error_d   = 1'b0;
                    if (sel_pub[PUBKEY_W-1 -: 3] == KEY_TAG_VALID) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_LOAD: begin
                tmo_d   = '0;
                state_d = ST_HASH;
            end
            ST_HASH: begin
                if (eng_counter == 3'b111) begin
                    correct_d = (eng_hash == exp_q);
                    error_d   = 1'b0;
                    state_d   = ST_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    correct_d = 1'b0;
                    error_d   = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rr_ptr_d = (id_q == LAST_ID) ? 3'd0 : id_q + 3'd1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        eng_resetn_d = (state_d == ST_HASH);
    end

    // Registered state; reset aborts any transaction in flight
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            exp_q        <= '0;
            key_q        <= '0;
            correct_q    <= 1'b0;
            error_q      <= 1'b0;
            tmo_q        <= '0;
            eng_resetn_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            exp_q        <= exp_d;
            key_q        <= key_d;
            correct_q    <= correct_d;
            error_q      <= error_d;
            tmo_q        <= tmo_d;
            eng_resetn_q <= eng_resetn_d;
        end
    end

    assign rsp_valid   = (state_q == ST_RESP);
    assign busy        = (state_q != ST_IDLE);
    assign rsp_id      = id_q;
    assign rsp_correct = correct_q;
    assign rsp_error   = error_q;

endmodule

// File: tb/tb_key_verify_scheduler.sv
// Self-checking bench for key_verify_scheduler.
// Vector table plus hand sequences; responses checked through a scoreboard.
module tb_key_verify_scheduler;
    import verilogicoin_pkg::*;

    localparam int N = 4;
    localparam logic [TABLE_W-1:0] TBL =
        {2'b10, 64'hA5C3_1F7E_9B24_D860, 64'h3C96_E1F0_7B2D_845A,
         64'h0F1E_2D3C_4B5A_6978, 64'hD2B4_8E61_5FA7_C309};

    logic                  clock = 1'b0;
    logic                  resetn;
    logic [TABLE_W-1:0]    tbl;
    logic [N-1:0]          req_valid;
    logic [N-1:0]          req_ready;
    logic [N*PUBKEY_W-1:0] req_public_key;
    logic [N*KEY_W-1:0]    req_input_key;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [2:0]            rsp_id;
    logic                  rsp_correct;
    logic                  rsp_error;
    logic                  busy;

    int n_vec = 0;
    int n_err = 0;
    int eng_hi_cnt = 0;

    typedef struct {
        logic [2:0] id;
        logic       c;
        logic       e;
    } exp_t;

    typedef struct {
        int         id;
        logic [2:0] tag;
        logic [7:0] hsh;
        logic [7:0] key;
        logic       c;
        int         lat;
    } vec_t;

    exp_t sb[$];
    vec_t vt[7];

    key_verify_scheduler #(.NUM_REQ(N), .TIMEOUT(15)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .random_table   (tbl),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_public_key (req_public_key),
        .req_input_key  (req_input_key),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_correct    (rsp_correct),
        .rsp_error      (rsp_error),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (dut.eng_resetn_q === 1'b1) eng_hi_cnt <= eng_hi_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gold_hash(input logic [7:0] msg);
        logic [7:0] h;
        logic [TABLE_W-1:0] t;
        h = 8'h00;
        t = TBL;
        for (int s = 0; s < 7; s++) begin
            h = {h[4:0], t[{1'b0, h ^ msg} +: 3]} ^ msg;
        end
        return h;
    endfunction

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic drive_lane(input int i, input logic [2:0] tag,
                              input logic [7:0] h, input logic [7:0] k);
        req_public_key[i*PUBKEY_W +: PUBKEY_W] = {tag, h};
        req_input_key[i*KEY_W +: KEY_W] = k;
    endtask

    // Called at a negedge in IDLE; returns at the negedge of cycle 1
    task automatic issue(input int i, input logic [2:0] tag,
                         input logic [7:0] h, input logic [7:0] k,
                         input logic expc, input logic expe, input string nm);
        exp_t e;
        drive_lane(i, tag, h, k);
        req_valid = N'(1) << i;
        #1;
        check({nm, " grant"}, 32'(req_ready), 32'(N'(1) << i));
        e.id = 3'(i);
        e.c  = expc;
        e.e  = expe;
        sb.push_back(e);
        @(negedge clock);
        req_valid = '0;
        drive_lane(i, ~tag, ~h, ~k);
    endtask

    task automatic wait_rsp(input string nm, input int exp_lat);
        int   lat;
        exp_t e;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        check({nm, " latency"}, lat, exp_lat);
        if (!rsp_valid) return;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got response want none", nm);
        end else begin
            e = sb.pop_front();
            check({nm, " id"}, 32'(rsp_id), 32'(e.id));
            check({nm, " correct"}, 32'(rsp_correct), 32'(e.c));
            check({nm, " error"}, 32'(rsp_error), 32'(e.e));
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        check({nm, " idle"}, {30'b0, rsp_valid, busy}, 32'd0);
    endtask

    task automatic rr_run(input logic [N-1:0] mask, input int order[$],
                          input string nm);
        int   g;
        int   guard;
        exp_t e;
        g = 0;
        guard = 0;
        for (int i = 0; i < N; i++) drive_lane(i, 3'b001, 8'h00, 8'h00);
        rsp_ready = 1'b1;
        req_valid = mask;
        while ((g < order.size() || sb.size() != 0) && guard < 60) begin
            if (g == order.size()) req_valid = '0;
            #1;
            if (rsp_valid && sb.size() != 0) begin
                e = sb.pop_front();
                check({nm, " rsp id"}, 32'(rsp_id), 32'(e.id));
            end
            if (req_ready != '0 && g < order.size()) begin
                check($sformatf("%s grant%0d", nm, g), 32'(req_ready),
                      32'(N'(1) << order[g]));
                e.id = 3'(order[g]);
                e.c  = 1'b0;
                e.e  = 1'b0;
                sb.push_back(e);
                g++;
            end
            @(negedge clock);
            guard++;
        end
        check({nm, " grants"}, g, order.size());
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        int base;
        tbl            = TBL;
        resetn         = 1'b0;
        req_valid      = '0;
        req_public_key = '0;
        req_input_key  = '0;
        rsp_ready      = 1'b0;

        vt[0] = '{1, 3'b010, gold_hash(8'h5A), 8'h5A, 1'b1, 10};
        vt[1] = '{1, 3'b010, gold_hash(8'h5A), 8'h5B,
                  gold_hash(8'h5B) == gold_hash(8'h5A), 10};
        vt[2] = '{2, 3'b001, 8'h00, 8'h00, 1'b0, 1};
        vt[3] = '{0, 3'b010, gold_hash(8'h00), 8'h00, 1'b1, 10};
        vt[4] = '{2, 3'b010, gold_hash(8'h33) ^ 8'h01, 8'h33, 1'b0, 10};
        vt[5] = '{3, 3'b010, gold_hash(8'hFF), 8'hFF, 1'b1, 10};
        vt[6] = '{3, 3'b111, gold_hash(8'hFF), 8'hFF, 1'b0, 1};

        repeat (3) @(negedge clock);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_id", 32'(rsp_id), 32'd0);
        check("rst correct", 32'(rsp_correct), 32'd0);
        check("rst error", 32'(rsp_error), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst req_ready", 32'(req_ready), 32'd0);
        resetn = 1'b1;
        @(negedge clock);

        for (int v = 0; v < 7; v++) begin
            base = eng_hi_cnt;
            issue(vt[v].id, vt[v].tag, vt[v].hsh, vt[v].key, vt[v].c, 1'b0,
                  $sformatf("vec%0d", v));
            wait_rsp($sformatf("vec%0d", v), vt[v].lat);
            check($sformatf("vec%0d engine", v), 32'(eng_hi_cnt != base),
                  32'(vt[v].tag == KEY_TAG_VALID));
        end

        rr_run(4'b1111, '{0, 1, 2, 3, 0}, "rr_all");
        issue(1, 3'b001, 8'h00, 8'h00, 1'b0, 1'b0, "ptr2");
        wait_rsp("ptr2", 1);
        rr_run(4'b1001, '{3, 0}, "rr_wrap");

        force dut.eng_counter = 3'b010;
        issue(0, 3'b010, gold_hash(8'h5A), 8'h5A, 1'b0, 1'b1, "tmo");
        wait_rsp("tmo", 17);
        release dut.eng_counter;
        @(negedge clock);

        issue(2, 3'b001, 8'h00, 8'h00, 1'b0, 1'b0, "ptr3");
        wait_rsp("ptr3", 1);

        drive_lane(3, 3'b010, gold_hash(8'h21), 8'h21);
        req_valid = 4'b1000;
        #1;
        check("abort grant", 32'(req_ready), 32'h8);
        @(negedge clock);
        req_valid = '0;
        repeat (5) @(negedge clock);
        check("abort busy before", 32'(busy), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("abort rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort rsp_id", 32'(rsp_id), 32'd0);
        check("abort correct", 32'(rsp_correct), 32'd0);
        check("abort error", 32'(rsp_error), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        drive_lane(1, 3'b010, gold_hash(8'hC7), 8'hC7);
        drive_lane(3, 3'b010, gold_hash(8'h21), 8'h21);
        req_valid = 4'b1010;
        #1;
        check("fresh grant", 32'(req_ready), 32'h2);
        sb.push_back('{3'd1, 1'b1, 1'b0});
        @(negedge clock);
        req_valid = '0;
        wait_rsp("fresh", 10);

        check("scoreboard empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
